// File: rtl/vigna_bus_mem.sv
// Dual-port valid/ready memory responder for the vigna instruction and data buses.
// Both ports share one word array through a tie-alternating arbiter, with per-port wait states.
module vigna_bus_mem #(
  parameter int unsigned MEM_WORDS = 1024,
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
  parameter int unsigned I_LATENCY = 1,
  parameter int unsigned D_LATENCY = 1,
  parameter string       INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_valid,
  output logic        i_ready,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  input  logic        d_valid,
  output logic        d_ready,
  input  logic [31:0] d_addr,
  output logic [31:0] d_rdata,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb
);

  localparam int unsigned AW    = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [3:0]  I_LAT = 4'(I_LATENCY);
  localparam logic [3:0]  D_LAT = 4'(D_LATENCY);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_PEND, ST_RESP} state_t;

  state_t      i_state, i_state_nx, d_state, d_state_nx;
  logic [3:0]  i_cnt, i_cnt_nx, d_cnt, d_cnt_nx;
  logic [31:0] i_addr_q, d_addr_q, d_wdata_q;
  logic [3:0]  d_wstrb_q;
  logic        last_grant_d;
  logic        i_accept, d_accept, grant_i, grant_d, tie;
  logic [31:0] acc_idx, acc_rd;
  logic        acc_hit;

  logic [31:0] mem [MEM_WORDS];

  always_comb begin
    tie      = (i_state == ST_PEND) && (d_state == ST_PEND);
    grant_i  = (i_state == ST_PEND) && (!tie || last_grant_d);
    grant_d  = (d_state == ST_PEND) && (!tie || !last_grant_d);
    i_accept = (i_state == ST_IDLE) && i_valid && !i_ready;
    d_accept = (d_state == ST_IDLE) && d_valid && !d_ready;

    i_state_nx = i_state;
    i_cnt_nx   = i_cnt;
    case (i_state)
      ST_IDLE: if (i_accept) begin
        i_cnt_nx   = I_LAT;
        i_state_nx = (I_LAT == 4'd0) ? ST_PEND : ST_WAIT;
      end
      ST_WAIT: begin
        i_cnt_nx = i_cnt - 4'd1;
        if (i_cnt <= 4'd1) i_state_nx = ST_PEND;
      end
      ST_PEND: if (grant_i) i_state_nx = ST_RESP;
      default: i_state_nx = ST_IDLE;
    endcase

    d_state_nx = d_state;
    d_cnt_nx   = d_cnt;
    case (d_state)
      ST_IDLE: if (d_accept) begin
        d_cnt_nx   = D_LAT;
        d_state_nx = (D_LAT == 4'd0) ? ST_PEND : ST_WAIT;
      end
      ST_WAIT: begin
        d_cnt_nx = d_cnt - 4'd1;
        if (d_cnt <= 4'd1) d_state_nx = ST_PEND;
      end
      ST_PEND: if (grant_d) d_state_nx = ST_RESP;
      default: d_state_nx = ST_IDLE;
    endcase

    // Index is taken after the base subtraction so addresses below the base wrap out of range.
    acc_idx = ((grant_d ? d_addr_q : i_addr_q) - ADDR_BASE) >> 2;
    acc_hit = acc_idx < 32'(MEM_WORDS);
    acc_rd  = acc_hit ? mem[acc_idx[AW-1:0]] : '0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      i_state      <= ST_IDLE;
      d_state      <= ST_IDLE;
      i_cnt        <= '0;
      d_cnt        <= '0;
      i_addr_q     <= '0;
      d_addr_q     <= '0;
      d_wdata_q    <= '0;
      d_wstrb_q    <= '0;
      i_ready      <= 1'b0;
      d_ready      <= 1'b0;
      i_rdata      <= '0;
      d_rdata      <= '0;
      last_grant_d <= 1'b0;
    end else begin
      i_state <= i_state_nx;
      d_state <= d_state_nx;
      i_cnt   <= i_cnt_nx;
      d_cnt   <= d_cnt_nx;
      if (i_accept) i_addr_q <= i_addr;
      if (d_accept) begin
        d_addr_q  <= d_addr;
        d_wdata_q <= d_wdata;
        d_wstrb_q <= d_wstrb;
      end
      i_ready <= grant_i;
      d_ready <= grant_d;
      if (grant_i) i_rdata <= acc_rd;
      if (grant_d && d_wstrb_q == 4'b0000) d_rdata <= acc_rd;
      // Only contested grants move the fairness pointer.
      if (tie) last_grant_d <= grant_d;
    end
  end

  always_ff @(posedge clk) begin
    if (grant_d && d_wstrb_q != 4'b0000 && acc_hit) begin
      for (int unsigned k = 0; k < 4; k++) begin
        if (d_wstrb_q[k]) mem[acc_idx[AW-1:0]][8*k +: 8] <= d_wdata_q[8*k +: 8];
      end
    end
  end

endmodule

// File: tb/tb_vigna_bus_mem.sv
// Directed bench for vigna_bus_mem: a zero-latency instance (b) and a slow instance (a, I=2, D=4).
module tb_vigna_bus_mem;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_resetn, a_i_valid, a_i_ready, a_d_valid, a_d_ready;
    logic [31:0] a_i_addr, a_i_rdata, a_d_addr, a_d_rdata, a_d_wdata;
    logic [3:0]  a_d_wstrb;
    logic        b_resetn, b_i_valid, b_i_ready, b_d_valid, b_d_ready;
    logic [31:0] b_i_addr, b_i_rdata, b_d_addr, b_d_rdata, b_d_wdata;
    logic [3:0]  b_d_wstrb;

    vigna_bus_mem #(.MEM_WORDS(1024), .ADDR_BASE(32'h0), .I_LATENCY(2), .D_LATENCY(4)) dut_a (
        .clk(clk), .resetn(a_resetn),
        .i_valid(a_i_valid), .i_ready(a_i_ready), .i_addr(a_i_addr), .i_rdata(a_i_rdata),
        .d_valid(a_d_valid), .d_ready(a_d_ready), .d_addr(a_d_addr), .d_rdata(a_d_rdata),
        .d_wdata(a_d_wdata), .d_wstrb(a_d_wstrb)
    );

    vigna_bus_mem #(.MEM_WORDS(1024), .ADDR_BASE(32'h0), .I_LATENCY(0), .D_LATENCY(0)) dut_b (
        .clk(clk), .resetn(b_resetn),
        .i_valid(b_i_valid), .i_ready(b_i_ready), .i_addr(b_i_addr), .i_rdata(b_i_rdata),
        .d_valid(b_d_valid), .d_ready(b_d_ready), .d_addr(b_d_addr), .d_rdata(b_d_rdata),
        .d_wdata(b_d_wdata), .d_wstrb(b_d_wstrb)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One D transaction; returns #1 after the edge that raised ready (ready still high).
    task automatic d_txn(input bit on_a, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, output int lat);
        logic rdy;
        @(posedge clk);
        @(negedge clk);
        if (on_a) begin
            a_d_addr = addr; a_d_wdata = wdata; a_d_wstrb = strb; a_d_valid = 1'b1;
        end else begin
            b_d_addr = addr; b_d_wdata = wdata; b_d_wstrb = strb; b_d_valid = 1'b1;
        end
        @(posedge clk);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
            rdy = on_a ? a_d_ready : b_d_ready;
        end while (!rdy && lat < 20);
        if (on_a) a_d_valid = 1'b0; else b_d_valid = 1'b0;
    endtask

    task automatic a_i_read(input logic [31:0] addr, output int lat);
        @(posedge clk);
        @(negedge clk);
        a_i_addr = addr; a_i_valid = 1'b1;
        @(posedge clk);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!a_i_ready && lat < 20);
        a_i_valid = 1'b0;
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[16];

    initial begin
        int lat;
        int saw_rdy;

        vecs[0]  = '{32'h0000_0000, 32'hA5A5_A5A5, 4'b1111, 32'h0000_0000};
        vecs[1]  = '{32'h0000_0020, 32'h1122_3344, 4'b1111, 32'h0000_0000};
        vecs[2]  = '{32'h0000_0020, 32'h0000_0000, 4'b0000, 32'h1122_3344};
        vecs[3]  = '{32'h0000_0020, 32'h0000_AB00, 4'b0010, 32'h1122_3344};
        vecs[4]  = '{32'h0000_0020, 32'h0000_0000, 4'b0000, 32'h1122_AB44};
        vecs[5]  = '{32'h0000_0020, 32'hCAFE_0000, 4'b1100, 32'h1122_AB44};
        vecs[6]  = '{32'h0000_0022, 32'h0000_0000, 4'b0000, 32'hCAFE_AB44};
        vecs[7]  = '{32'h0000_1000, 32'h0000_0000, 4'b0000, 32'h0000_0000};
        vecs[8]  = '{32'h0000_1000, 32'hFFFF_FFFF, 4'b1111, 32'h0000_0000};
        vecs[9]  = '{32'h0000_0000, 32'h0000_0000, 4'b0000, 32'hA5A5_A5A5};
        vecs[10] = '{32'hFFFF_FFFC, 32'h0000_0000, 4'b0000, 32'h0000_0000};
        vecs[11] = '{32'h0000_0FFC, 32'h8765_4321, 4'b1111, 32'h0000_0000};
        vecs[12] = '{32'h0000_0FFC, 32'h0000_0000, 4'b0000, 32'h8765_4321};
        vecs[13] = '{32'hFFFF_FFFC, 32'hFFFF_FFFF, 4'b1111, 32'h8765_4321};
        vecs[14] = '{32'h0000_0000, 32'h0000_0000, 4'b0000, 32'hA5A5_A5A5};
        vecs[15] = '{32'h0000_0FFC, 32'h0000_0000, 4'b0000, 32'h8765_4321};

        a_resetn = 1'b0; a_i_valid = 1'b0; a_d_valid = 1'b0;
        a_i_addr = '0; a_d_addr = '0; a_d_wdata = '0; a_d_wstrb = '0;
        b_resetn = 1'b0; b_i_valid = 1'b1; b_d_valid = 1'b1;
        b_i_addr = 32'h0000_1000; b_d_addr = 32'h0000_1000; b_d_wdata = '0; b_d_wstrb = '0;

        // Reset held with requests asserted.
        repeat (4) begin
            @(negedge clk);
            check32("reset_ready", {28'd0, a_i_ready, a_d_ready, b_i_ready, b_d_ready}, 32'd0);
            check32("reset_b_i_rdata", b_i_rdata, 32'h0);
            check32("reset_b_d_rdata", b_d_rdata, 32'h0);
        end
        a_resetn = 1'b1;
        b_resetn = 1'b1;
        @(posedge clk); #1;
        check32("rel_edgeA_ready", {30'd0, b_i_ready, b_d_ready}, 32'd0);
        @(posedge clk); #1;
        check32("rel_first_tie_d", {30'd0, b_i_ready, b_d_ready}, 32'd1);
        check32("rel_d_rdata_oor", b_d_rdata, 32'h0);
        b_d_valid = 1'b0;
        @(posedge clk); #1;
        check32("rel_first_tie_i", {30'd0, b_i_ready, b_d_ready}, 32'd2);
        check32("rel_i_rdata_oor", b_i_rdata, 32'h0);
        b_i_valid = 1'b0;

        // Table of D-port transactions on the zero-latency instance.
        for (int i = 0; i < 16; i++) begin
            d_txn(1'b0, vecs[i].addr, vecs[i].wdata, vecs[i].strb, lat);
            check32($sformatf("vec%0d_latency", i), 32'(lat), 32'd1);
            check32($sformatf("vec%0d_rdata", i), b_d_rdata, vecs[i].exp_rdata);
        end

        // Arbitration: fresh reset, then two back-to-back ties.
        @(negedge clk); b_resetn = 1'b0;
        @(negedge clk); b_resetn = 1'b1;
        b_i_addr = 32'h0000_0000; b_d_addr = 32'h0000_0020; b_d_wstrb = 4'b0000;
        b_i_valid = 1'b1; b_d_valid = 1'b1;
        @(posedge clk); #1;
        check32("arb1_edgeA", {30'd0, b_i_ready, b_d_ready}, 32'd0);
        @(posedge clk); #1;
        check32("arb1_d_first", {30'd0, b_i_ready, b_d_ready}, 32'd1);
        b_d_valid = 1'b0;
        @(posedge clk); #1;
        check32("arb1_i_second", {30'd0, b_i_ready, b_d_ready}, 32'd2);
        b_i_valid = 1'b0;
        check32("arb1_i_rdata", b_i_rdata, 32'hA5A5_A5A5);
        check32("arb1_d_rdata", b_d_rdata, 32'hCAFE_AB44);
        @(posedge clk);
        @(negedge clk);
        b_i_addr = 32'h0000_0FFC; b_d_addr = 32'h0000_0000;
        b_i_valid = 1'b1; b_d_valid = 1'b1;
        @(posedge clk); #1;
        check32("arb2_edgeA", {30'd0, b_i_ready, b_d_ready}, 32'd0);
        @(posedge clk); #1;
        check32("arb2_i_first", {30'd0, b_i_ready, b_d_ready}, 32'd2);
        b_i_valid = 1'b0;
        @(posedge clk); #1;
        check32("arb2_d_second", {30'd0, b_i_ready, b_d_ready}, 32'd1);
        b_d_valid = 1'b0;
        check32("arb2_i_rdata", b_i_rdata, 32'h8765_4321);
        check32("arb2_d_rdata", b_d_rdata, 32'hA5A5_A5A5);
        @(posedge clk); #1;
        check32("arb2_pulse_end", {30'd0, b_i_ready, b_d_ready}, 32'd0);

        // Latency on the slow instance.
        d_txn(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'b1111, lat);
        check32("a_d_write_latency", 32'(lat), 32'd5);
        a_i_read(32'h0000_0010, lat);
        check32("a_i_latency", 32'(lat), 32'd3);
        check32("a_i_rdata", a_i_rdata, 32'hDEAD_BEEF);
        @(posedge clk); #1;
        check32("a_i_ready_pulse", {31'd0, a_i_ready}, 32'd0);
        repeat (3) @(posedge clk);
        #1 check32("a_i_rdata_held", a_i_rdata, 32'hDEAD_BEEF);

        // Reset during WAIT discards a pending write.
        d_txn(1'b1, 32'h0000_0040, 32'h0000_0000, 4'b1111, lat);
        check32("a_clear_latency", 32'(lat), 32'd5);
        @(posedge clk);
        @(negedge clk);
        a_d_addr = 32'h0000_0040; a_d_wdata = 32'h1234_5678; a_d_wstrb = 4'b1111; a_d_valid = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #3 a_resetn = 1'b0;
        a_d_valid = 1'b0;
        #1 check32("midwait_ready_low", {31'd0, a_d_ready}, 32'd0);
        saw_rdy = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (a_d_ready) saw_rdy++;
        end
        @(negedge clk); a_resetn = 1'b1;
        repeat (8) begin
            @(posedge clk); #1;
            if (a_d_ready) saw_rdy++;
        end
        check32("midwait_no_pulse", 32'(saw_rdy), 32'd0);
        d_txn(1'b1, 32'h0000_0040, 32'h0, 4'b0000, lat);
        check32("midwait_read_latency", 32'(lat), 32'd5);
        check32("midwait_write_dropped", a_d_rdata, 32'h0000_0000);

        // Granted write survives reset; reset clears a live ready asynchronously.
        d_txn(1'b1, 32'h0000_0010, 32'h0, 4'b0000, lat);
        check32("retained_latency", 32'(lat), 32'd5);
        check32("retained_rdata", a_d_rdata, 32'hDEAD_BEEF);
        #1 a_resetn = 1'b0;
        #1 check32("async_ready_clear", {31'd0, a_d_ready}, 32'd0);
        check32("async_rdata_clear", a_d_rdata, 32'h0);
        @(negedge clk); a_resetn = 1'b1;
        repeat (2) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
